multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle control unit for the MIPS datapath. Sequences fetch, decode, execute, memory and write-back over several clocks, and shares one ALU and one unified memory port across those phases. It decodes the same instruction subset and drives the same mux-select encodings as the single-cycle decoder. It adds a memory-ready handshake, an illegal-opcode flag and a retired-instruction counter.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
opcode  in  6  IR[31:26]; valid from DECODE onward (IR is loaded at the end of FETCH).
func  in  6  IR[5:0].
mem_ready  in  1  memory completes the current access this cycle.
zero  in  1  ALU equal flag, used in BRANCH.
PCWrite  out  1  unconditional PC load.
PCWriteCond  out  1  PC load when zero=1.
PCSource  out  2  00 = ALU result, 01 = ALUOut register.
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
IRWrite  out  1  IR load.
MemRead  out  1  memory read request.
MemWrite  out  1  memory write request.
RegWrite  out  1  register file write enable.
RegDst  out  2  REG_MUX_SEL_RT / REG_MUX_SEL_RD.
DatatoReg  out  2  DR_MUX_SEL_ALU / DR_MUX_SEL_MEM.
ALUSrcA  out  1  0 = PC, 1 = register A.
ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = extended imm, 11 = extended imm<<2.
ALUCtrl  out  5  ALUOp_* code.
ExtOp  out  1  EXT_SIGNED / EXT_ZERO.
state  out  4  current state, for debug.
illegal  out  1  one-cycle pulse on an undecodable instruction.
instr_retired  out  CNT_W  count of completed instructions.

Behaviour:
- Clock and reset: clk rising edge; rst asynchronous active-high. On reset, state=FETCH (0) and instr_retired=0.
- Output timing: all control outputs are combinational from state, opcode and func. A control output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9. Codes 10-15 go to FETCH on the next clock.
- FETCH:
  - Always: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtrl=ADD.
  - While mem_ready=0: stay in FETCH with IRWrite=0 and PCWrite=0.
  - When mem_ready=1: IRWrite=1, PCWrite=1, PCSource=00; next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUCtrl=ADD, ExtOp=signed (branch target into ALUOut). Next state by instruction:
  - R-type with func add/sub/addu/subu -> EXEC_R.
  - ori/lui/slti -> EXEC_I.
  - lw/sw -> MEM_ADDR.
  - beq -> BRANCH.
  - Any other opcode, or R-type with any other func -> FETCH, with illegal=1 for this cycle. Not counted as retired.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUCtrl = ADD/SUB/ADDU/SUBU per func. Next state WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10. Next state WB_ALU.
  - ori: ALUCtrl=OR, ExtOp=zero.
  - lui: ALUCtrl=LUI, ExtOp=zero.
  - slti: ALUCtrl=SLT, ExtOp=signed.
- WB_ALU: RegWrite=1, DatatoReg=ALU. RegDst=RD for R-type, RT otherwise. Next state FETCH; retire.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUCtrl=ADD, ExtOp=signed. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1. Hold until mem_ready=1, then go to WB_MEM.
- WB_MEM: RegWrite=1, RegDst=RT, DatatoReg=MEM. Next state FETCH; retire.
- MEM_WR: MemWrite=1, IorD=1. Hold until mem_ready=1, then go to FETCH; retire.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUCtrl=EQL, PCWriteCond=1, PCSource=01. Next state FETCH; retire whether or not the branch is taken.
- Request stability: MemRead/MemWrite stay asserted and stable through every wait cycle. RegWrite/PCWrite/IRWrite never assert during a wait except on the completing cycle as stated.
- Retire counter: instr_retired increments by 1 on each clock edge marked "retire". It wraps from all-ones to 0.
- Latency with mem_ready tied to 1:
  - R-type/I-type ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
- Reset mid-operation: returns immediately to FETCH with the counter cleared. No partial write is counted.

Test Plan:
- Hold rst=1, then release with mem_ready=1 and an addu opcode/func -> state sequence 0,1,2,7,0; RegWrite=1 only in state 7 with RegDst=RD; instr_retired=1.
- lw with mem_ready low for 3 cycles in MEM_RD -> state stays 5 for 3 cycles with MemRead=1, IorD=1 stable; then 8, RegWrite=1, DatatoReg=MEM; total 8 cycles.
- beq with zero=1, then beq with zero=0 -> PCWriteCond=1, PCSource=01 in state 9 both times; instr_retired increments 2.
- Opcode 6'b111111 -> DECODE -> FETCH with a single illegal pulse; instr_retired unchanged.
- Assert rst asynchronously during MEM_WR -> state=0 and instr_retired=0 before the next edge; MemWrite drops immediately.
- Preload the counter path by running 2^CNT_W instructions with CNT_W=4 -> instr_retired wraps to 0 after 16 retirements.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/write-back
// around one shared ALU and one unified memory port, and counts retired instructions.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   input  logic             mem_ready,
   input  logic             zero,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic [1:0]       PCSource,
   output logic             IorD,
   output logic             IRWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic [1:0]       RegDst,
   output logic [1:0]       DatatoReg,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [4:0]       ALUCtrl,
   output logic             ExtOp,
   output logic [3:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_retired
);

   // Mux-select and ALU encodings shared with the single-cycle decoder.
   localparam logic [1:0] REG_MUX_SEL_RT = 2'd1;
   localparam logic [1:0] REG_MUX_SEL_RD = 2'd2;
   localparam logic [1:0] DR_MUX_SEL_ALU = 2'd1;
   localparam logic [1:0] DR_MUX_SEL_MEM = 2'd2;
   localparam logic       EXT_SIGNED     = 1'b1;
   localparam logic       EXT_ZERO       = 1'b0;

   localparam logic [4:0] ALUOp_ADD  = 5'd1;
   localparam logic [4:0] ALUOp_ADDU = 5'd2;
   localparam logic [4:0] ALUOp_SUB  = 5'd3;
   localparam logic [4:0] ALUOp_SUBU = 5'd4;
   localparam logic [4:0] ALUOp_OR   = 5'd5;
   localparam logic [4:0] ALUOp_SLT  = 5'd6;
   localparam logic [4:0] ALUOp_LUI  = 5'd7;
   localparam logic [4:0] ALUOp_EQL  = 5'd8;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_EXEC_R   = 4'd2;
   localparam logic [3:0] S_EXEC_I   = 4'd3;
   localparam logic [3:0] S_MEM_ADDR = 4'd4;
   localparam logic [3:0] S_MEM_RD   = 4'd5;
   localparam logic [3:0] S_MEM_WR   = 4'd6;
   localparam logic [3:0] S_WB_ALU   = 4'd7;
   localparam logic [3:0] S_WB_MEM   = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;

   logic [3:0] state_q, state_d;
   logic       retire;
   logic       r_ok;
   logic [4:0] r_alu;

   assign state = state_q;

   always_comb begin
      r_ok  = 1'b1;
      r_alu = ALUOp_ADD;
      case (func)
         F_ADD:   r_alu = ALUOp_ADD;
         F_ADDU:  r_alu = ALUOp_ADDU;
         F_SUB:   r_alu = ALUOp_SUB;
         F_SUBU:  r_alu = ALUOp_SUBU;
         default: r_ok  = 1'b0;
      endcase
      if (opcode != OP_RTYPE) r_ok = 1'b0;
   end

   // Memory handshake: MemRead/MemWrite is the request and is held steady until
   // a cycle with mem_ready=1, which completes the access in that same cycle.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = 2'b00;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 2'b00;
      DatatoReg   = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUCtrl     = 5'd0;
      ExtOp       = 1'b0;
      illegal     = 1'b0;
      retire      = 1'b0;
      state_d     = S_FETCH;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            ALUCtrl = ALUOp_ADD;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            ALUCtrl = ALUOp_ADD;
            ExtOp   = EXT_SIGNED;
            if (r_ok)                                                 state_d = S_EXEC_R;
            else if (opcode == OP_ORI || opcode == OP_LUI || opcode == OP_SLTI) state_d = S_EXEC_I;
            else if (opcode == OP_LW || opcode == OP_SW)              state_d = S_MEM_ADDR;
            else if (opcode == OP_BEQ)                                state_d = S_BRANCH;
            else                                                      illegal = 1'b1;
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUCtrl = r_alu;
            state_d = S_WB_ALU;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (opcode)
               OP_ORI:  begin ALUCtrl = ALUOp_OR;  ExtOp = EXT_ZERO;   end
               OP_LUI:  begin ALUCtrl = ALUOp_LUI; ExtOp = EXT_ZERO;   end
               default: begin ALUCtrl = ALUOp_SLT; ExtOp = EXT_SIGNED; end
            endcase
            state_d = S_WB_ALU;
         end
         S_WB_ALU: begin
            RegWrite  = 1'b1;
            DatatoReg = DR_MUX_SEL_ALU;
            RegDst    = (opcode == OP_RTYPE) ? REG_MUX_SEL_RD : REG_MUX_SEL_RT;
            retire    = 1'b1;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUCtrl = ALUOp_ADD;
            ExtOp   = EXT_SIGNED;
            state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
         end
         S_WB_MEM: begin
            RegWrite  = 1'b1;
            RegDst    = REG_MUX_SEL_RT;
            DatatoReg = DR_MUX_SEL_MEM;
            retire    = 1'b1;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            state_d  = mem_ready ? S_FETCH : S_MEM_WR;
            retire   = mem_ready;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUCtrl     = ALUOp_EQL;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            retire      = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_FETCH;
         instr_retired <= '0;
      end else begin
         state_q <= state_d;
         if (retire) instr_retired <= instr_retired + 1'b1;
      end
   end

endmodule
